// File: rtl/stream_demux1_2_16b_slot.sv
// demux_slot_16b: one-entry holding register for one demux output channel.
// Ports: clk, rst (async high), i_load, i_data, i_ready -> o_valid, o_data.
//   i_load  : latch i_data this cycle (already qualified by accept + select)
//   i_ready : downstream consumer takes the held word this cycle
//   o_valid : slot FULL; o_data : held word (stale when o_valid=0)
module demux_slot_16b #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [N-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [N-1:0] o_data
);

    logic         r_valid;
    logic [N-1:0] r_data;
    logic         w_drain;
    logic         w_valid_nxt;

    assign w_drain     = r_valid & i_ready;
    // A load in the same cycle as a drain refills the slot (full throughput).
    assign w_valid_nxt = i_load | (r_valid & ~w_drain);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
        end
    end

    // Data only moves on load; a drained slot keeps its stale word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/stream_demux1_2_16b.sv
// stream_demux1_2_16b: registered 1-to-2 valid/ready stream demultiplexer.
// Ports: clk, rst (async high); InData/InSel/InValid -> InReady;
//   OutA/OutAValid <- OutAReady; OutB/OutBValid <- OutBReady.
//   InSel=0 routes to channel A, InSel=1 to channel B; one cycle latency.
module stream_demux1_2_16b #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] InData,
    input  logic         InSel,
    input  logic         InValid,
    output logic         InReady,
    output logic [N-1:0] OutA,
    output logic         OutAValid,
    input  logic         OutAReady,
    output logic [N-1:0] OutB,
    output logic         OutBValid,
    input  logic         OutBReady
);

    logic w_ready_a;
    logic w_ready_b;
    logic w_accept;
    logic w_load_a;
    logic w_load_b;

    // Ready only looks at the selected channel: a stalled selected channel
    // blocks the input even if the other one is free (no reordering).
    assign w_ready_a = ~OutAValid | OutAReady;
    assign w_ready_b = ~OutBValid | OutBReady;
    assign InReady   = InSel ? w_ready_b : w_ready_a;

    assign w_accept = InValid & InReady;
    assign w_load_a = w_accept & ~InSel;
    assign w_load_b = w_accept &  InSel;

    demux_slot_16b #(.N(N)) u_slot_a (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load_a),
        .i_data  (InData),
        .i_ready (OutAReady),
        .o_valid (OutAValid),
        .o_data  (OutA)
    );

    demux_slot_16b #(.N(N)) u_slot_b (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load_b),
        .i_data  (InData),
        .i_ready (OutBReady),
        .o_valid (OutBValid),
        .o_data  (OutB)
    );

endmodule

// File: tb/tb_stream_demux1_2_16b.sv
// Directed bench for stream_demux1_2_16b: reset, routing, back-pressure,
// streaming, drain+load overlap, drain without reload, async reset.
module tb_stream_demux1_2_16b;

    logic        clk;
    logic        rst;
    logic [15:0] InData;
    logic        InSel;
    logic        InValid;
    logic        InReady;
    logic [15:0] OutA;
    logic        OutAValid;
    logic        OutAReady;
    logic [15:0] OutB;
    logic        OutBValid;
    logic        OutBReady;

    int total;
    int bad;

    stream_demux1_2_16b #(.N(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .InData    (InData),
        .InSel     (InSel),
        .InValid   (InValid),
        .InReady   (InReady),
        .OutA      (OutA),
        .OutAValid (OutAValid),
        .OutAReady (OutAReady),
        .OutB      (OutB),
        .OutBValid (OutBValid),
        .OutBReady (OutBReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        InValid = 1'b0; InSel = 1'b0; InData = 16'h0;
        OutAReady = 1'b0; OutBReady = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++;
        if (OutAValid !== 1'b0) begin
            bad++; $display("FAIL reset_avalid got=%b exp=0", OutAValid);
        end
        total++;
        if (OutBValid !== 1'b0) begin
            bad++; $display("FAIL reset_bvalid got=%b exp=0", OutBValid);
        end
        total++;
        if (OutA !== 16'h0) begin
            bad++; $display("FAIL reset_outa got=%h exp=0000", OutA);
        end
        total++;
        if (OutB !== 16'h0) begin
            bad++; $display("FAIL reset_outb got=%h exp=0000", OutB);
        end
        total++;
        if (InReady !== 1'b1) begin
            bad++; $display("FAIL reset_inready got=%b exp=1", InReady);
        end
        step();
    endtask

    task automatic test_single_routes();
        InData = 16'hBEEF; InSel = 1'b0; InValid = 1'b1;
        #1;
        total++;
        if (InReady !== 1'b1) begin
            bad++; $display("FAIL route_a_ready got=%b exp=1", InReady);
        end
        step();
        InValid = 1'b0;
        total++;
        if (OutA !== 16'hBEEF || OutAValid !== 1'b1 || OutBValid !== 1'b0) begin
            bad++;
            $display("FAIL route_a got=%h/%b/%b exp=beef/1/0",
                     OutA, OutAValid, OutBValid);
        end
        InData = 16'h1234; InSel = 1'b1; InValid = 1'b1;
        #1;
        total++;
        if (InReady !== 1'b1) begin
            bad++; $display("FAIL route_b_ready got=%b exp=1", InReady);
        end
        step();
        InValid = 1'b0;
        total++;
        if (OutB !== 16'h1234 || OutBValid !== 1'b1) begin
            bad++; $display("FAIL route_b got=%h/%b exp=1234/1", OutB, OutBValid);
        end
        total++;
        if (OutA !== 16'hBEEF || OutAValid !== 1'b1) begin
            bad++; $display("FAIL route_b_a_hold got=%h/%b exp=beef/1",
                            OutA, OutAValid);
        end
    endtask

    task automatic test_backpressure();
        OutAReady = 1'b1; OutBReady = 1'b1;
        step();
        OutAReady = 1'b0; OutBReady = 1'b0;
        total++;
        if (OutAValid !== 1'b0 || OutBValid !== 1'b0) begin
            bad++; $display("FAIL bp_drain got=%b/%b exp=0/0", OutAValid, OutBValid);
        end
        InData = 16'h0001; InSel = 1'b0; InValid = 1'b1;
        step();
        InData = 16'h0002;
        #1;
        total++;
        if (InReady !== 1'b0) begin
            bad++; $display("FAIL bp_hol_ready got=%b exp=0", InReady);
        end
        step();
        total++;
        if (OutA !== 16'h0001 || OutAValid !== 1'b1) begin
            bad++; $display("FAIL bp_hold_a got=%h/%b exp=0001/1", OutA, OutAValid);
        end
        InData = 16'h0003; InSel = 1'b1;
        #1;
        total++;
        if (InReady !== 1'b1) begin
            bad++; $display("FAIL bp_other_ready got=%b exp=1", InReady);
        end
        step();
        InValid = 1'b0;
        total++;
        if (OutB !== 16'h0003 || OutBValid !== 1'b1 || OutA !== 16'h0001) begin
            bad++;
            $display("FAIL bp_route_b got=%h/%b a=%h exp=0003/1 a=0001",
                     OutB, OutBValid, OutA);
        end
    endtask

    task automatic test_streaming();
        logic [15:0] w;
        OutAReady = 1'b1; OutBReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w = 16'h0010 + 16'(i);
            InData = w; InSel = 1'b0; InValid = 1'b1;
            #1;
            total++;
            if (InReady !== 1'b1) begin
                bad++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, InReady);
            end
            step();
            total++;
            if (OutA !== w || OutAValid !== 1'b1) begin
                bad++;
                $display("FAIL stream_word[%0d] got=%h/%b exp=%h/1",
                         i, OutA, OutAValid, w);
            end
            total++;
            if (OutB !== 16'h0003 || OutBValid !== 1'b1) begin
                bad++;
                $display("FAIL stream_b_hold[%0d] got=%h/%b exp=0003/1",
                         i, OutB, OutBValid);
            end
        end
        InValid = 1'b0;
        OutAReady = 1'b0;
    endtask

    task automatic test_drain_load();
        total++;
        if (OutA !== 16'h0017 || OutAValid !== 1'b1) begin
            bad++; $display("FAIL dl_pre got=%h/%b exp=0017/1", OutA, OutAValid);
        end
        OutAReady = 1'b1;
        InData = 16'hA5A5; InSel = 1'b0; InValid = 1'b1;
        #1;
        total++;
        if (InReady !== 1'b1) begin
            bad++; $display("FAIL dl_ready got=%b exp=1", InReady);
        end
        step();
        InValid = 1'b0;
        total++;
        if (OutA !== 16'hA5A5 || OutAValid !== 1'b1) begin
            bad++; $display("FAIL dl_a got=%h/%b exp=a5a5/1", OutA, OutAValid);
        end
        total++;
        if (OutB !== 16'h0003 || OutBValid !== 1'b1) begin
            bad++; $display("FAIL dl_b got=%h/%b exp=0003/1", OutB, OutBValid);
        end
        step();
        OutAReady = 1'b0;
        total++;
        if (OutAValid !== 1'b0 || OutA !== 16'hA5A5) begin
            bad++; $display("FAIL drain_stale got=%h/%b exp=a5a5/0", OutA, OutAValid);
        end
        total++;
        if (OutBValid !== 1'b1) begin
            bad++; $display("FAIL drain_b_indep got=%b exp=1", OutBValid);
        end
    endtask

    task automatic test_async_reset();
        InData = 16'h5555; InSel = 1'b0; InValid = 1'b1;
        step();
        InValid = 1'b0;
        total++;
        if (OutAValid !== 1'b1 || OutBValid !== 1'b1) begin
            bad++; $display("FAIL ar_pre got=%b/%b exp=1/1", OutAValid, OutBValid);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (OutAValid !== 1'b0 || OutBValid !== 1'b0) begin
            bad++; $display("FAIL ar_valids got=%b/%b exp=0/0", OutAValid, OutBValid);
        end
        total++;
        if (OutA !== 16'h0 || OutB !== 16'h0) begin
            bad++; $display("FAIL ar_data got=%h/%h exp=0000/0000", OutA, OutB);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (OutAValid !== 1'b0 || OutBValid !== 1'b0) begin
                bad++;
                $display("FAIL ar_idle[%0d] got=%b/%b exp=0/0",
                         i, OutAValid, OutBValid);
            end
        end
        InData = 16'h7777; InSel = 1'b1; InValid = 1'b1;
        step();
        InValid = 1'b0;
        total++;
        if (OutB !== 16'h7777 || OutBValid !== 1'b1 || OutAValid !== 1'b0) begin
            bad++;
            $display("FAIL ar_new got=%h/%b a=%b exp=7777/1 a=0",
                     OutB, OutBValid, OutAValid);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_routes();
        test_backpressure();
        test_streaming();
        test_drain_load();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
